// File: rtl/fakeram7_dp_pkg.sv
// Shared constants and types for the 512x128 dual-port fakeram7 request front-end.
package fakeram7_dp_pkg;

  localparam int BITS       = 128;
  localparam int WORD_DEPTH = 512;
  localparam int ADDR_WIDTH = 9;

  typedef logic [BITS-1:0] rdata_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [BITS-1:0]       wdata;
    logic [BITS-1:0]       wmask;
  } req_t;

endpackage

// File: rtl/fakeram7_dp_rsp_fifo.sv
// Small synchronous read-response FIFO with an occupancy count; one instance per RAM port.
module fakeram7_dp_rsp_fifo
  import fakeram7_dp_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [BITS-1:0] din,
  input  logic            pop,
  output logic [BITS-1:0] dout,
  output logic [CW-1:0]   count,
  output logic            empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rdata_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/fakeram7_dp_req_ctrl.sv
// Valid/ready request front-end for the dual-port fakeram7 macro with credited in-order read responses.
// Define FAKERAM7_DP_REQ_CTRL_COLL_CNT_EN to add the saturating coll_cnt output.
module fakeram7_dp_req_ctrl
  import fakeram7_dp_pkg::*;
#(
  parameter int RSP_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_a,
  output logic                  req_ready_a,
  input  logic                  req_we_a,
  input  logic [ADDR_WIDTH-1:0] req_addr_a,
  input  logic [BITS-1:0]       req_wdata_a,
  input  logic [BITS-1:0]       req_wmask_a,
  input  logic                  req_valid_b,
  output logic                  req_ready_b,
  input  logic                  req_we_b,
  input  logic [ADDR_WIDTH-1:0] req_addr_b,
  input  logic [BITS-1:0]       req_wdata_b,
  input  logic [BITS-1:0]       req_wmask_b,
  output logic                  rsp_valid_a,
  input  logic                  rsp_ready_a,
  output logic [BITS-1:0]       rsp_rdata_a,
  output logic                  rsp_valid_b,
  input  logic                  rsp_ready_b,
  output logic [BITS-1:0]       rsp_rdata_b,
  output logic                  ram_ce,
  output logic                  ram_we_A,
  output logic                  ram_we_B,
  output logic [ADDR_WIDTH-1:0] ram_addr_A,
  output logic [ADDR_WIDTH-1:0] ram_addr_B,
  output logic [BITS-1:0]       ram_wd_A,
  output logic [BITS-1:0]       ram_wd_B,
  output logic [BITS-1:0]       ram_wmask_A,
  output logic [BITS-1:0]       ram_wmask_B,
  input  logic [BITS-1:0]       ram_rd_A,
  input  logic [BITS-1:0]       ram_rd_B
`ifdef FAKERAM7_DP_REQ_CTRL_COLL_CNT_EN
  ,
  output logic [15:0]           coll_cnt
`endif
);

  localparam int CW  = $clog2(RSP_DEPTH + 1);
  localparam int CW1 = CW + 1;

  req_t                  req_a, req_b;
  rdata_t                head_a, head_b;
  logic                  run_q;
  logic                  inflight_a, inflight_b;
  logic [ADDR_WIDTH-1:0] hold_addr_a, hold_addr_b;
  logic [CW-1:0]         count_a, count_b;
  logic                  empty_a, empty_b;
  logic                  credit_a, credit_b;
  logic                  accept_a, accept_b;
  logic                  coll;
  logic                  push_a, push_b, pop_a, pop_b;

  assign req_a = '{we: req_we_a, addr: req_addr_a, wdata: req_wdata_a, wmask: req_wmask_a};
  assign req_b = '{we: req_we_b, addr: req_addr_b, wdata: req_wdata_b, wmask: req_wmask_b};

  // Every accepted read reserves a FIFO slot up front, so data arriving from the stall-free macro always has a home.
  assign credit_a = run_q && (({1'b0, count_a} + CW1'(inflight_a)) < CW1'(RSP_DEPTH));
  assign credit_b = run_q && (({1'b0, count_b} + CW1'(inflight_b)) < CW1'(RSP_DEPTH));

  assign accept_a    = req_valid_a & credit_a;
  assign coll        = accept_a & req_a.we & req_valid_b & req_b.we & (req_a.addr == req_b.addr);
  assign req_ready_a = credit_a;
  assign req_ready_b = credit_b & ~coll;
  assign accept_b    = req_valid_b & req_ready_b;

  assign ram_ce      = accept_a | accept_b;
  assign ram_we_A    = accept_a & req_a.we;
  assign ram_we_B    = accept_b & req_b.we;
  assign ram_addr_A  = accept_a ? req_a.addr : hold_addr_a;
  assign ram_addr_B  = accept_b ? req_b.addr : hold_addr_b;
  assign ram_wd_A    = ram_we_A ? req_a.wdata : '0;
  assign ram_wd_B    = ram_we_B ? req_b.wdata : '0;
  assign ram_wmask_A = ram_we_A ? req_a.wmask : '0;
  assign ram_wmask_B = ram_we_B ? req_b.wmask : '0;

  // run_q keeps ram_ce low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q       <= 1'b0;
      inflight_a  <= 1'b0;
      inflight_b  <= 1'b0;
      hold_addr_a <= '0;
      hold_addr_b <= '0;
    end else begin
      run_q      <= 1'b1;
      inflight_a <= accept_a & ~req_a.we;
      inflight_b <= accept_b & ~req_b.we;
      if (accept_a) hold_addr_a <= req_a.addr;
      if (accept_b) hold_addr_b <= req_b.addr;
    end
  end

  // Fresh macro data skips the FIFO only when nothing older is queued and the consumer takes it now.
  assign push_a      = inflight_a & ~(empty_a & rsp_ready_a);
  assign push_b      = inflight_b & ~(empty_b & rsp_ready_b);
  assign pop_a       = ~empty_a & rsp_ready_a;
  assign pop_b       = ~empty_b & rsp_ready_b;
  assign rsp_valid_a = inflight_a | ~empty_a;
  assign rsp_valid_b = inflight_b | ~empty_b;
  assign rsp_rdata_a = empty_a ? ram_rd_A : head_a;
  assign rsp_rdata_b = empty_b ? ram_rd_B : head_b;

  fakeram7_dp_rsp_fifo #(.DEPTH(RSP_DEPTH), .CW(CW)) u_fifo_a (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_a),
    .din   (ram_rd_A),
    .pop   (pop_a),
    .dout  (head_a),
    .count (count_a),
    .empty (empty_a)
  );

  fakeram7_dp_rsp_fifo #(.DEPTH(RSP_DEPTH), .CW(CW)) u_fifo_b (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_b),
    .din   (ram_rd_B),
    .pop   (pop_b),
    .dout  (head_b),
    .count (count_b),
    .empty (empty_b)
  );

`ifdef FAKERAM7_DP_REQ_CTRL_COLL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll_cnt <= '0;
    end else if (coll && (coll_cnt != 16'hFFFF)) begin
      coll_cnt <= coll_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fakeram7_dp_req_ctrl.sv
// Self-checking bench for fakeram7_dp_req_ctrl: behavioural macro, transaction-level reference model,
// directed scenarios and a randomized run. Also checks coll_cnt when FAKERAM7_DP_REQ_CTRL_COLL_CNT_EN is set.
module tb_fakeram7_dp_req_ctrl;
  import fakeram7_dp_pkg::*;

  localparam int RSP_DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n;
  logic                  req_valid_a, req_ready_a, req_we_a;
  logic [ADDR_WIDTH-1:0] req_addr_a;
  logic [BITS-1:0]       req_wdata_a, req_wmask_a;
  logic                  req_valid_b, req_ready_b, req_we_b;
  logic [ADDR_WIDTH-1:0] req_addr_b;
  logic [BITS-1:0]       req_wdata_b, req_wmask_b;
  logic                  rsp_valid_a, rsp_ready_a, rsp_valid_b, rsp_ready_b;
  logic [BITS-1:0]       rsp_rdata_a, rsp_rdata_b;
  logic                  ram_ce, ram_we_A, ram_we_B;
  logic [ADDR_WIDTH-1:0] ram_addr_A, ram_addr_B;
  logic [BITS-1:0]       ram_wd_A, ram_wd_B, ram_wmask_A, ram_wmask_B;
  logic [BITS-1:0]       ram_rd_A, ram_rd_B;
`ifdef FAKERAM7_DP_REQ_CTRL_COLL_CNT_EN
  logic [15:0]           coll_cnt;
`endif

  fakeram7_dp_req_ctrl #(.RSP_DEPTH(RSP_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_a(req_valid_a), .req_ready_a(req_ready_a), .req_we_a(req_we_a), .req_addr_a(req_addr_a),
    .req_wdata_a(req_wdata_a), .req_wmask_a(req_wmask_a),
    .req_valid_b(req_valid_b), .req_ready_b(req_ready_b), .req_we_b(req_we_b), .req_addr_b(req_addr_b),
    .req_wdata_b(req_wdata_b), .req_wmask_b(req_wmask_b),
    .rsp_valid_a(rsp_valid_a), .rsp_ready_a(rsp_ready_a), .rsp_rdata_a(rsp_rdata_a),
    .rsp_valid_b(rsp_valid_b), .rsp_ready_b(rsp_ready_b), .rsp_rdata_b(rsp_rdata_b),
    .ram_ce(ram_ce), .ram_we_A(ram_we_A), .ram_we_B(ram_we_B), .ram_addr_A(ram_addr_A), .ram_addr_B(ram_addr_B),
    .ram_wd_A(ram_wd_A), .ram_wd_B(ram_wd_B), .ram_wmask_A(ram_wmask_A), .ram_wmask_B(ram_wmask_B),
    .ram_rd_A(ram_rd_A), .ram_rd_B(ram_rd_B)
`ifdef FAKERAM7_DP_REQ_CTRL_COLL_CNT_EN
    , .coll_cnt(coll_cnt)
`endif
  );

  // Behavioural stand-in for the macro: reads see pre-write contents, one-cycle latency.
  logic [BITS-1:0] mem [WORD_DEPTH];
  always @(posedge clk) begin
    if (ram_ce) begin
      if (!ram_we_A) ram_rd_A <= mem[ram_addr_A];
      if (!ram_we_B) ram_rd_B <= mem[ram_addr_B];
      if (ram_we_A) mem[ram_addr_A] <= (mem[ram_addr_A] & ~ram_wmask_A) | (ram_wd_A & ram_wmask_A);
      if (ram_we_B) mem[ram_addr_B] <= (mem[ram_addr_B] & ~ram_wmask_B) | (ram_wd_B & ram_wmask_B);
    end
  end

  // Reference model: golden memory plus per-port queues of outstanding read results.
  logic [BITS-1:0]       gold [WORD_DEPTH];
  logic [BITS-1:0]       exp_q_a[$];
  logic [BITS-1:0]       exp_q_b[$];
  logic [ADDR_WIDTH-1:0] last_addr_a, last_addr_b;
  logic                  e_ready_a, e_ready_b, e_acc_a, e_acc_b, e_coll;
  int                    e_coll_cnt;
  int                    checks = 0;
  int                    failures = 0;

  function automatic logic [BITS-1:0] rand_word();
    logic [BITS-1:0] w;
    for (int i = 0; i < BITS / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return 9'h010;
      1:       return 9'h1FF;
      2:       return 9'h005;
      default: return 9'h020;
    endcase
  endfunction

  task automatic set_idle();
    req_valid_a = 1'b0; req_we_a = 1'b0; req_addr_a = '0; req_wdata_a = '0; req_wmask_a = '0;
    req_valid_b = 1'b0; req_we_b = 1'b0; req_addr_b = '0; req_wdata_b = '0; req_wmask_b = '0;
    rsp_ready_a = 1'b0; rsp_ready_b = 1'b0;
  endtask

  task automatic model_clear();
    exp_q_a.delete();
    exp_q_b.delete();
    last_addr_a = '0;
    last_addr_b = '0;
    e_coll_cnt  = 0;
  endtask

  task automatic begin_cycle();
    @(negedge clk);
    e_ready_a = exp_q_a.size() < RSP_DEPTH;
    e_acc_a   = req_valid_a && e_ready_a;
    e_coll    = e_acc_a && req_we_a && req_valid_b && req_we_b && (req_addr_a == req_addr_b);
    e_ready_b = (exp_q_b.size() < RSP_DEPTH) && !e_coll;
    e_acc_b   = req_valid_b && e_ready_b;
  endtask

  task automatic finish_cycle();
    if (rsp_ready_a && exp_q_a.size() > 0) void'(exp_q_a.pop_front());
    if (rsp_ready_b && exp_q_b.size() > 0) void'(exp_q_b.pop_front());
    if (e_acc_a && !req_we_a) exp_q_a.push_back(gold[req_addr_a]);
    if (e_acc_b && !req_we_b) exp_q_b.push_back(gold[req_addr_b]);
    if (e_acc_a) last_addr_a = req_addr_a;
    if (e_acc_b) last_addr_b = req_addr_b;
    if (e_acc_a && req_we_a) gold[req_addr_a] = (gold[req_addr_a] & ~req_wmask_a) | (req_wdata_a & req_wmask_a);
    if (e_acc_b && req_we_b) gold[req_addr_b] = (gold[req_addr_b] & ~req_wmask_b) | (req_wdata_b & req_wmask_b);
    if (e_coll && e_coll_cnt < 65535) e_coll_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    set_idle();
    for (int i = 0; i < n; i++) begin
      begin_cycle();
      finish_cycle();
    end
  endtask

  task automatic test_reset();
    set_idle();
    req_valid_a = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rsp_valid_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_valid_a got=%b exp=0", rsp_valid_a); end
    checks++; if (ram_ce !== 1'b0) begin failures++; $display("[TB] FAIL reset_ram_ce got=%b exp=0", ram_ce); end
    checks++; if (ram_addr_A !== 9'h000) begin failures++; $display("[TB] FAIL reset_ram_addr_A got=%h exp=000", ram_addr_A); end
    checks++; if (ram_we_B !== 1'b0) begin failures++; $display("[TB] FAIL reset_ram_we_B got=%b exp=0", ram_we_B); end
    set_idle();
    rst_n = 1'b1;
    model_clear();
    idle_cycles(2);
  endtask

  task automatic test_write_read();
    set_idle();
    req_valid_a = 1'b1; req_we_a = 1'b1; req_addr_a = 9'h010;
    req_wdata_a = {8{16'hAAAA}}; req_wmask_a = '1;
    begin_cycle();
    checks++; if (req_ready_a !== 1'b1) begin failures++; $display("[TB] FAIL wr_ready_a got=%b exp=1", req_ready_a); end
    checks++; if ({ram_ce, ram_we_A, ram_addr_A} !== {1'b1, 1'b1, 9'h010}) begin failures++; $display("[TB] FAIL wr_pins_a got=%b%b%h exp=11010", ram_ce, ram_we_A, ram_addr_A); end
    checks++; if (ram_wd_A !== {8{16'hAAAA}}) begin failures++; $display("[TB] FAIL wr_wd_a got=%h", ram_wd_A); end
    finish_cycle();
    req_we_a = 1'b0; req_wdata_a = '0; req_wmask_a = '0; rsp_ready_a = 1'b1;
    begin_cycle();
    checks++; if ({ram_ce, ram_we_A} !== 2'b10) begin failures++; $display("[TB] FAIL rd_pins_a got=%b%b exp=10", ram_ce, ram_we_A); end
    checks++; if (rsp_valid_a !== 1'b0) begin failures++; $display("[TB] FAIL rd_early_valid_a got=%b exp=0", rsp_valid_a); end
    finish_cycle();
    req_valid_a = 1'b0;
    begin_cycle();
    checks++; if (rsp_valid_a !== 1'b1) begin failures++; $display("[TB] FAIL rd_valid_a got=%b exp=1", rsp_valid_a); end
    checks++; if (rsp_rdata_a !== {8{16'hAAAA}}) begin failures++; $display("[TB] FAIL rd_data_a got=%h exp=%h", rsp_rdata_a, {8{16'hAAAA}}); end
    checks++; if ({ram_ce, ram_addr_A, ram_wd_A} !== {1'b0, 9'h010, {BITS{1'b0}}}) begin failures++; $display("[TB] FAIL idle_pins_a got ce=%b addr=%h wd=%h", ram_ce, ram_addr_A, ram_wd_A); end
    finish_cycle();
  endtask

  task automatic test_masked_write_b();
    set_idle();
    req_valid_b = 1'b1; req_we_b = 1'b1; req_addr_b = 9'h010;
    req_wdata_b = {8{16'h5555}}; req_wmask_b = {8{16'h00FF}};
    begin_cycle();
    checks++; if (ram_wmask_B !== {8{16'h00FF}}) begin failures++; $display("[TB] FAIL mwr_wmask_b got=%h", ram_wmask_B); end
    finish_cycle();
    req_we_b = 1'b0; req_wdata_b = '0; req_wmask_b = '0; rsp_ready_b = 1'b1;
    begin_cycle();
    finish_cycle();
    req_valid_b = 1'b0;
    begin_cycle();
    checks++; if (rsp_valid_b !== 1'b1) begin failures++; $display("[TB] FAIL mrd_valid_b got=%b exp=1", rsp_valid_b); end
    checks++; if (rsp_rdata_b !== {8{16'hAA55}}) begin failures++; $display("[TB] FAIL mrd_data_b got=%h exp=%h", rsp_rdata_b, {8{16'hAA55}}); end
    finish_cycle();
  endtask

  task automatic test_backpressure();
    logic [BITS-1:0] v [3];
    for (int i = 0; i < 3; i++) begin
      v[i] = {4{32'hC0DE_0000 + 32'(i)}};
      set_idle();
      req_valid_a = 1'b1; req_we_a = 1'b1; req_addr_a = 9'h020 + 9'(i); req_wdata_a = v[i]; req_wmask_a = '1;
      begin_cycle();
      finish_cycle();
    end
    set_idle();
    req_valid_a = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_addr_a = 9'h020 + 9'(i);
      begin_cycle();
      checks++; if (req_ready_a !== 1'b1) begin failures++; $display("[TB] FAIL bp_accept_%0d got=%b exp=1", i, req_ready_a); end
      finish_cycle();
    end
    req_addr_a = 9'h022;
    for (int i = 0; i < 2; i++) begin
      begin_cycle();
      checks++; if (req_ready_a !== 1'b0) begin failures++; $display("[TB] FAIL bp_blocked_%0d got=%b exp=0", i, req_ready_a); end
      finish_cycle();
    end
    rsp_ready_a = 1'b1;
    begin_cycle();
    checks++; if (rsp_rdata_a !== v[0] || req_ready_a !== 1'b0) begin failures++; $display("[TB] FAIL bp_first got=%h ready=%b exp=%h ready=0", rsp_rdata_a, req_ready_a, v[0]); end
    finish_cycle();
    begin_cycle();
    checks++; if (rsp_rdata_a !== v[1] || req_ready_a !== 1'b1) begin failures++; $display("[TB] FAIL bp_second got=%h ready=%b exp=%h ready=1", rsp_rdata_a, req_ready_a, v[1]); end
    finish_cycle();
    req_valid_a = 1'b0;
    begin_cycle();
    checks++; if (rsp_valid_a !== 1'b1 || rsp_rdata_a !== v[2]) begin failures++; $display("[TB] FAIL bp_third got=%h valid=%b exp=%h", rsp_rdata_a, rsp_valid_a, v[2]); end
    finish_cycle();
    begin_cycle();
    checks++; if (rsp_valid_a !== 1'b0) begin failures++; $display("[TB] FAIL bp_drained got=%b exp=0", rsp_valid_a); end
    finish_cycle();
  endtask

  task automatic test_collision();
    set_idle();
    req_valid_a = 1'b1; req_we_a = 1'b1; req_addr_a = 9'h1FF; req_wdata_a = {32{4'h1}}; req_wmask_a = '1;
    req_valid_b = 1'b1; req_we_b = 1'b1; req_addr_b = 9'h1FF; req_wdata_b = {32{4'h2}}; req_wmask_b = '1;
    begin_cycle();
    checks++; if ({req_ready_a, req_ready_b, ram_we_B} !== 3'b100) begin failures++; $display("[TB] FAIL coll_stall got=%b%b%b exp=100", req_ready_a, req_ready_b, ram_we_B); end
    finish_cycle();
    req_valid_a = 1'b0; req_we_a = 1'b0;
    begin_cycle();
    checks++; if ({req_ready_b, ram_we_B} !== 2'b11) begin failures++; $display("[TB] FAIL coll_retry got=%b%b exp=11", req_ready_b, ram_we_B); end
`ifdef FAKERAM7_DP_REQ_CTRL_COLL_CNT_EN
    checks++; if (coll_cnt !== 16'd1) begin failures++; $display("[TB] FAIL coll_cnt got=%0d exp=1", coll_cnt); end
`endif
    finish_cycle();
    set_idle();
    req_valid_a = 1'b1; req_addr_a = 9'h1FF; rsp_ready_a = 1'b1;
    begin_cycle();
    finish_cycle();
    req_valid_a = 1'b0;
    begin_cycle();
    checks++; if (rsp_rdata_a !== {32{4'h2}}) begin failures++; $display("[TB] FAIL coll_final got=%h exp=%h", rsp_rdata_a, {32{4'h2}}); end
    finish_cycle();
  endtask

  task automatic test_write_read_same();
    set_idle();
    req_valid_a = 1'b1; req_we_a = 1'b1; req_addr_a = 9'h005; req_wdata_a = {32{4'h3}}; req_wmask_a = '1;
    begin_cycle();
    finish_cycle();
    req_wdata_a = {32{4'h7}};
    req_valid_b = 1'b1; req_addr_b = 9'h005; rsp_ready_b = 1'b1;
    begin_cycle();
    checks++; if ({req_ready_a, req_ready_b, ram_ce} !== 3'b111) begin failures++; $display("[TB] FAIL wrs_issue got=%b%b%b exp=111", req_ready_a, req_ready_b, ram_ce); end
    finish_cycle();
    req_valid_a = 1'b0; req_we_a = 1'b0;
    begin_cycle();
    checks++; if (rsp_rdata_b !== {32{4'h3}}) begin failures++; $display("[TB] FAIL wrs_old got=%h exp=%h", rsp_rdata_b, {32{4'h3}}); end
    finish_cycle();
    req_valid_b = 1'b0;
    begin_cycle();
    checks++; if (rsp_rdata_b !== {32{4'h7}}) begin failures++; $display("[TB] FAIL wrs_new got=%h exp=%h", rsp_rdata_b, {32{4'h7}}); end
    finish_cycle();
  endtask

  task automatic test_reset_midflight();
    set_idle();
    req_valid_a = 1'b1; req_addr_a = 9'h010;
    begin_cycle();
    finish_cycle();
    req_addr_a = 9'h1FF;
    begin_cycle();
    finish_cycle();
    rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid_a !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_valid got=%b exp=0", rsp_valid_a); end
    checks++; if (ram_ce !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_ce got=%b exp=0", ram_ce); end
    checks++; if ($isunknown({ram_addr_A, ram_addr_B}) || ram_addr_A !== 9'h000) begin failures++; $display("[TB] FAIL mid_rst_addr got=%h exp=000", ram_addr_A); end
    repeat (2) @(posedge clk);
    #1;
    set_idle();
    rst_n = 1'b1;
    rsp_ready_a = 1'b1;
    model_clear();
    for (int i = 0; i < 5; i++) begin
      begin_cycle();
      checks++; if (rsp_valid_a !== 1'b0 || $isunknown({ram_addr_A, ram_addr_B})) begin failures++; $display("[TB] FAIL mid_rst_stale cyc=%0d valid=%b addr=%h", i, rsp_valid_a, ram_addr_A); end
      finish_cycle();
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 600; cyc++) begin
      req_valid_a = ($urandom_range(0, 3) != 0); req_we_a = $urandom_range(0, 1); req_addr_a = pick_addr();
      req_wdata_a = rand_word(); req_wmask_a = $urandom_range(0, 1) ? '1 : rand_word();
      req_valid_b = ($urandom_range(0, 3) != 0); req_we_b = $urandom_range(0, 1); req_addr_b = pick_addr();
      req_wdata_b = rand_word(); req_wmask_b = $urandom_range(0, 1) ? '1 : rand_word();
      rsp_ready_a = ($urandom_range(0, 3) != 0); rsp_ready_b = ($urandom_range(0, 2) != 0);
      begin_cycle();
      checks++; if (req_ready_a !== e_ready_a) begin failures++; $display("[TB] FAIL rnd_ready_a cyc=%0d got=%b exp=%b", cyc, req_ready_a, e_ready_a); end
      checks++; if (req_ready_b !== e_ready_b) begin failures++; $display("[TB] FAIL rnd_ready_b cyc=%0d got=%b exp=%b", cyc, req_ready_b, e_ready_b); end
      checks++; if (ram_ce !== (e_acc_a | e_acc_b)) begin failures++; $display("[TB] FAIL rnd_ce cyc=%0d got=%b exp=%b", cyc, ram_ce, e_acc_a | e_acc_b); end
      checks++; if ({ram_we_A, ram_we_B} !== {e_acc_a & req_we_a, e_acc_b & req_we_b}) begin failures++; $display("[TB] FAIL rnd_we cyc=%0d got=%b%b", cyc, ram_we_A, ram_we_B); end
      checks++; if (ram_addr_A !== (e_acc_a ? req_addr_a : last_addr_a)) begin failures++; $display("[TB] FAIL rnd_addr_a cyc=%0d got=%h", cyc, ram_addr_A); end
      checks++; if (ram_addr_B !== (e_acc_b ? req_addr_b : last_addr_b)) begin failures++; $display("[TB] FAIL rnd_addr_b cyc=%0d got=%h", cyc, ram_addr_B); end
      checks++; if (ram_wd_A !== ((e_acc_a && req_we_a) ? req_wdata_a : '0)) begin failures++; $display("[TB] FAIL rnd_wd_a cyc=%0d got=%h", cyc, ram_wd_A); end
      checks++; if (rsp_valid_a !== (exp_q_a.size() > 0)) begin failures++; $display("[TB] FAIL rnd_valid_a cyc=%0d got=%b exp=%b", cyc, rsp_valid_a, exp_q_a.size() > 0); end
      checks++; if (rsp_valid_b !== (exp_q_b.size() > 0)) begin failures++; $display("[TB] FAIL rnd_valid_b cyc=%0d got=%b exp=%b", cyc, rsp_valid_b, exp_q_b.size() > 0); end
      if (exp_q_a.size() > 0) begin
        checks++; if (rsp_rdata_a !== exp_q_a[0]) begin failures++; $display("[TB] FAIL rnd_data_a cyc=%0d got=%h exp=%h", cyc, rsp_rdata_a, exp_q_a[0]); end
      end
      if (exp_q_b.size() > 0) begin
        checks++; if (rsp_rdata_b !== exp_q_b[0]) begin failures++; $display("[TB] FAIL rnd_data_b cyc=%0d got=%h exp=%h", cyc, rsp_rdata_b, exp_q_b[0]); end
      end
`ifdef FAKERAM7_DP_REQ_CTRL_COLL_CNT_EN
      checks++; if (coll_cnt !== 16'(e_coll_cnt)) begin failures++; $display("[TB] FAIL rnd_coll_cnt cyc=%0d got=%0d exp=%0d", cyc, coll_cnt, e_coll_cnt); end
`endif
      finish_cycle();
    end
    set_idle();
    rsp_ready_a = 1'b1; rsp_ready_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      begin_cycle();
      finish_cycle();
    end
    begin_cycle();
    checks++; if ({rsp_valid_a, rsp_valid_b} !== 2'b00) begin failures++; $display("[TB] FAIL rnd_drain got=%b%b exp=00", rsp_valid_a, rsp_valid_b); end
    finish_cycle();
  endtask

  initial begin
    model_clear();
    test_reset();
    test_write_read();
    test_masked_write_b();
    test_backpressure();
    test_collision();
    test_write_read_same();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fakeram7_dp_req_ctrl.md
Name: fakeram7_dp_req_ctrl

Overview:
Request front-end for the 512x128 dual-port fakeram7 macro. It turns two independent valid/ready request streams (ports A and B) into the macro's raw per-cycle pin protocol and drives the shared chip-enable. It tracks the macro's fixed one-cycle read latency, which has no stall, and returns read data on per-port valid/ready response streams. A credited response FIFO per port prevents data loss. It sits directly upstream of the RAM macro and directly consumes its rd_out_A/rd_out_B.

Parameters:
BITS, 128, data and mask width
WORD_DEPTH, 512, words in the macro
ADDR_WIDTH, 9, address width; must equal clog2(WORD_DEPTH)
RSP_DEPTH, 2, response FIFO entries per port; minimum 2

Ports:
clk  in  1  clock, shared with the RAM macro
rst_n  in  1  asynchronous active-low reset
req_valid_{a,b}  in  1  request valid
req_ready_{a,b}  out  1  request accepted when valid&ready
req_we_{a,b}  in  1  1=masked write, 0=read
req_addr_{a,b}  in  ADDR_WIDTH  word address
req_wdata_{a,b}  in  BITS  write data
req_wmask_{a,b}  in  BITS  per-bit write enable
rsp_valid_{a,b}  out  1  read data valid
rsp_ready_{a,b}  in  1  consumer accepts read data
rsp_rdata_{a,b}  out  BITS  read data
ram_ce  out  1  to ce_in
ram_we_{A,B}  out  1  to we_in_A/B
ram_addr_{A,B}  out  ADDR_WIDTH  to addr_in_A/B
ram_wd_{A,B}  out  BITS  to wd_in_A/B
ram_wmask_{A,B}  out  BITS  to w_mask_in_A/B
ram_rd_{A,B}  in  BITS  from rd_out_A/B

Behaviour:
- Reset (async assert, sync deassert in the clk domain): FIFOs empty, inflight flags 0, held addresses 0. rsp_valid=0, ram_ce=0, ram_we=0, ram_addr=0.
- Issue: accept = valid & ready. The RAM pins are driven combinationally in the accept cycle N; the macro samples them at the end of N.
- Idle port: ram_we=0; ram_addr holds the last issued address (registered), so it is never X. ram_wd and ram_wmask are forced to 0.
- ram_ce = accept_a | accept_b. This avoids the macro forcing X onto the other port when ce is low.
- Reads: inflight_x <= 1 at the end of N. In N+1, ram_rd_x is valid.
  - If FIFO_x is empty and rsp_ready_x=1, it bypasses straight to rsp (latency 1).
  - Otherwise it is pushed into FIFO_x.
  - rsp_valid_x = inflight_x | !empty_x. Responses come out strictly in order per port.
- Writes produce no response and do not touch the FIFO or credits.
- Credit: req_ready_x = (count_x + inflight_x) < RSP_DEPTH. A write is also blocked while credit is exhausted, so ordering stays simple.
- Collision: both ports accept writes to the same address in the same cycle → A wins. B's req_ready is deasserted combinationally that cycle and B retries next cycle.
- Write A with read B (or the reverse) to the same address in the same cycle: the read returns the old data. Both issue.
- Read/read to the same address: both issue.
- Reset mid-operation: inflight reads are dropped and FIFO contents are lost. No response is emitted after reset.

Optional Feature:
FAKERAM7_DP_REQ_CTRL_COLL_CNT_EN.
- Defined: adds output coll_cnt[15:0], a saturating count of write/write same-address collisions (B stalled). It resets to 0 and sticks at 16'hFFFF.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package fakeram7_dp_pkg: BITS, WORD_DEPTH and ADDR_WIDTH constants; the req_t struct {we, addr, wdata, wmask}; the rdata_t typedef.
- Sub-module fakeram7_dp_rsp_fifo: synchronous FIFO with count output, instantiated once per port. It is RSP_DEPTH deep and BITS wide, with bypass handled in the parent.

Test Plan:
- Write A addr 0x010 data 0xAAAA…, mask all-1s. Then read A 0x010 with rsp_ready=1 → rsp_valid_a in cycle N+1, rdata 0xAAAA…
- Masked write on B: mask 0x00FF… over old 0xAAAA…, wdata 0x5555… → B read returns 0xAA55…-pattern, with only the masked bits changed.
- rsp_ready_a held 0. Issue 3 back-to-back reads → first two accepted, req_ready_a low on the 3rd. Release rsp_ready → data in issue order, then the 3rd is accepted.
- Same-cycle writes A and B to 0x1FF (0x1… and 0x2…) → B stalls one cycle, final content 0x2…, coll_cnt=1 when the macro is defined.
- Same-cycle write A 0x005=0x7… and read B 0x005 (old 0x3…) → B returns 0x3…; a subsequent read returns 0x7…
- Assert rst_n=0 while a read is inflight and the FIFO holds 1 entry → rsp_valid=0 immediately, ram_ce=0. No stale response after release; ram_addr is never X throughout.
